perf_counter_csr: RTL and testbench
===================================

# perf_counter_csr

Machine performance-counter block for the RISC-V core: maintains 64-bit cycle and instructions-retired counters, honours an inhibit register, and serves them over a registered CSR read/write port. It sits beside the register-file write-back stage in `top` and takes the retire pulse from it. It exports `cycle_count`/`instret_count` as flat debug outputs for benches, and CSR reads replace the hierarchical probing of core internals.

## Interface
- `CNT_W`, 64, counter width in bits; legal range 33..64, upper half = bits `CNT_W-1:32`, zero-extended on reads.
- `USER_ALIAS`, 1, when 1 the read-only user aliases `0xC00`/`0xC02`/`0xC80`/`0xC82` decode; when 0 they are illegal.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instret_pulse`  in  1  one-cycle pulse per retired instruction (register-file write-enable qualified retire).
- `halt`  in  1  core halted; while high neither counter advances.
- `csr_addr`  in  12  CSR address.
- `csr_rd_en`  in  1  read request, single cycle.
- `csr_wr_en`  in  1  write request, single cycle.
- `csr_wdata`  in  32  write data.
- `csr_rdata`  out  32  read data, valid when `csr_valid`.
- `csr_valid`  out  1  one-cycle response strobe for either request.
- `csr_err`  out  1  qualifies `csr_valid`: illegal address, write to read-only alias, or `rd_en` and `wr_en` both high.
- `cycle_count`  out  CNT_W  live cycle counter.
- `instret_count`  out  CNT_W  live retired-instruction counter.

## Operation
- Address map:
  - `0xB00` mcycle[31:0], `0xB80` mcycle[63:32].
  - `0xB02` minstret[31:0], `0xB82` minstret[63:32].
  - `0x320` mcountinhibit; only bit 0 (CY) and bit 2 (IR) are implemented, other bits read 0 and ignore writes.
  - `0xC00`, `0xC80`, `0xC02`, `0xC82` are read-only aliases of the above.
- Cycle counter: +1 every clock when `!halt && !inhibit.CY`.
- Instret counter: +1 on a cycle with `instret_pulse && !halt && !inhibit.IR`.
- Wrap-around: both counters wrap from all-ones to 0 silently.
- Writes:
  - Writing a low half replaces bits 31:0 and keeps the upper bits.
  - Writing a high half replaces the upper bits and keeps bits 31:0.
  - A CSR write to a counter takes priority over that counter's increment in the same cycle. The written value is stored exactly and that cycle's increment is dropped.
  - Writing mcountinhibit takes effect from the next cycle. The increment in the write cycle uses the old inhibit value.
- Errors:
  - Illegal address, or a write to a user alias: `csr_err`=1, `csr_rdata`=0, no state change.
  - `csr_rd_en` and `csr_wr_en` both high: treated as an error, no write.
- Reads return the counter value sampled at the request edge, i.e. before that cycle's increment.
- Write response: `csr_rdata`=0.

## Timing
- Reset values: counters 0, inhibit 0, `csr_rdata`=0, `csr_valid`=0, `csr_err`=0.
- Reset asserted mid-operation clears everything immediately. Any pending response is dropped; `csr_valid` does not fire for a request made in the reset cycle.
- Response latency: exactly 1 cycle. A request at edge N gives `csr_valid`=1 for cycle N+1 only.
- Throughput: back-to-back requests every cycle are legal.
- `cycle_count` and `instret_count` are the counter registers themselves (0-cycle latency after the updating edge).
- Carry from bit 31 into bit 32 happens in the same cycle; there is no split-cycle carry.
- Halt: `halt` high freezes both counters on that edge. CSR access stays fully functional while halted.

## Test plan
- Reset release, 100 clocks with `halt`=0 and no `instret_pulse` -> `cycle_count`=100, `instret_count`=0. A read of `0xB00` at edge 100 returns 100 with `csr_valid` one cycle later.
- 40 `instret_pulse`s scattered over 120 cycles, then `halt`=1 for 50 cycles -> `instret_count`=40, `cycle_count`=120 and frozen. Reads of `0xC02` and `0xB82` return 40 and 0.
- Write `0xB00`=`0xFFFFFFFE`, `0xB80`=0 -> after 3 unhalted cycles `cycle_count`=`0x1_0000_0001`, and `0xB80` reads 1.
- Write `0x320`=`0x5` -> both counters hold. Write `0x320`=0 -> counting resumes next cycle. Bit 1 written as 1 reads back 0.
- Write to `0xC00`, read of `0x123`, and simultaneous `rd_en`+`wr_en` -> each gives `csr_valid`=1, `csr_err`=1, rdata 0, counters unaffected beyond normal increment.
- Assert `rst` asynchronously mid-count with a read in flight -> all outputs 0 immediately, no `csr_valid` after release, counting restarts from 0.

Source files
------------

// File: rtl/perf_counter_csr.sv
// Machine cycle / instret performance counters with mcountinhibit and a
// registered single-cycle CSR read/write port.

module perf_cnt #(
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_wr_lo,
   input  logic             i_wr_hi,
   input  logic [31:0]      i_wdata,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;

   // A CSR write wins over the increment; the written value lands exactly.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        r_cnt <= '0;
      else if (i_wr_lo) r_cnt <= {r_cnt[CNT_W-1:32], i_wdata};
      else if (i_wr_hi) r_cnt <= {i_wdata[CNT_W-33:0], r_cnt[31:0]};
      else if (i_inc)   r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_cnt = r_cnt;
endmodule

module perf_counter_csr #(
   parameter int CNT_W      = 64,
   parameter bit USER_ALIAS = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_instret_pulse,
   input  logic             i_halt,
   input  logic [11:0]      i_csr_addr,
   input  logic             i_csr_rd_en,
   input  logic             i_csr_wr_en,
   input  logic [31:0]      i_csr_wdata,
   output logic [31:0]      o_csr_rdata,
   output logic             o_csr_valid,
   output logic             o_csr_err,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [CNT_W-1:0] o_instret_count
);
   localparam int NCNT = 2;  // index 0 = mcycle, 1 = minstret

   logic                       r_inh_cy, r_inh_ir;
   logic                       r_valid, r_err;
   logic [31:0]                r_rdata;

   logic [NCNT-1:0][CNT_W-1:0] w_cnt;
   logic [NCNT-1:0]            w_inc, w_wr_lo, w_wr_hi;
   logic                       w_is_cnt, w_is_inh, w_is_hi, w_alias, w_idx;
   logic                       w_req, w_legal, w_err, w_wr_ok, w_rd_ok;
   logic [31:0]                w_rdval;

   always_comb begin
      w_is_cnt = 1'b0;
      w_is_inh = 1'b0;
      w_is_hi  = 1'b0;
      w_alias  = 1'b0;
      w_idx    = 1'b0;
      case (i_csr_addr)
         12'hB00: begin w_is_cnt = 1'b1; end
         12'hB80: begin w_is_cnt = 1'b1; w_is_hi = 1'b1; end
         12'hB02: begin w_is_cnt = 1'b1; w_idx = 1'b1; end
         12'hB82: begin w_is_cnt = 1'b1; w_idx = 1'b1; w_is_hi = 1'b1; end
         12'h320: begin w_is_inh = 1'b1; end
         12'hC00: if (USER_ALIAS) begin w_is_cnt = 1'b1; w_alias = 1'b1; end
         12'hC80: if (USER_ALIAS) begin w_is_cnt = 1'b1; w_alias = 1'b1; w_is_hi = 1'b1; end
         12'hC02: if (USER_ALIAS) begin w_is_cnt = 1'b1; w_alias = 1'b1; w_idx = 1'b1; end
         12'hC82: if (USER_ALIAS) begin
            w_is_cnt = 1'b1; w_alias = 1'b1; w_idx = 1'b1; w_is_hi = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_req   = i_csr_rd_en | i_csr_wr_en;
   assign w_legal = w_is_cnt | w_is_inh;
   assign w_err   = w_req & ((i_csr_rd_en & i_csr_wr_en) | ~w_legal | (i_csr_wr_en & w_alias));
   assign w_wr_ok = i_csr_wr_en & ~i_csr_rd_en & w_legal & ~w_alias;
   assign w_rd_ok = i_csr_rd_en & ~i_csr_wr_en & w_legal;

   // Reads see the pre-increment counter value; upper half is zero-extended.
   always_comb begin
      if (w_is_inh)     w_rdval = {29'b0, r_inh_ir, 1'b0, r_inh_cy};
      else if (w_is_hi) w_rdval = 32'(w_cnt[w_idx] >> 32);
      else              w_rdval = w_cnt[w_idx][31:0];
   end

   // Increments use the inhibit bits as they stood before this edge.
   assign w_inc[0] = ~i_halt & ~r_inh_cy;
   assign w_inc[1] = i_instret_pulse & ~i_halt & ~r_inh_ir;

   for (genvar k = 0; k < NCNT; k++) begin : g_cnt
      assign w_wr_lo[k] = w_wr_ok & w_is_cnt & (w_idx == k[0]) & ~w_is_hi;
      assign w_wr_hi[k] = w_wr_ok & w_is_cnt & (w_idx == k[0]) &  w_is_hi;
      perf_cnt #(.CNT_W(CNT_W)) u_cnt (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_inc   (w_inc[k]),
         .i_wr_lo (w_wr_lo[k]),
         .i_wr_hi (w_wr_hi[k]),
         .i_wdata (i_csr_wdata),
         .o_cnt   (w_cnt[k])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_inh_cy <= 1'b0;
         r_inh_ir <= 1'b0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_wr_ok && w_is_inh) begin
            r_inh_cy <= i_csr_wdata[0];
            r_inh_ir <= i_csr_wdata[2];
         end
         r_valid <= w_req;
         r_err   <= w_err;
         r_rdata <= w_rd_ok ? w_rdval : 32'b0;
      end
   end

   assign o_csr_rdata     = r_rdata;
   assign o_csr_valid     = r_valid;
   assign o_csr_err       = r_err;
   assign o_cycle_count   = w_cnt[0];
   assign o_instret_count = w_cnt[1];
endmodule

// File: tb/tb_perf_counter_csr.sv
// Scoreboard bench for perf_counter_csr: expected CSR responses queued at
// request time, popped when the response strobe is due.

module tb_perf_counter_csr;
   logic        clk = 1'b0, rst = 1'b1;
   logic        instret_pulse = 1'b0, halt = 1'b0;
   logic [11:0] csr_addr = '0;
   logic        csr_rd_en = 1'b0, csr_wr_en = 1'b0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        csr_valid, csr_err;
   logic [63:0] cycle_count, instret_count;

   perf_counter_csr #(.CNT_W(64), .USER_ALIAS(1'b1)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_instret_pulse (instret_pulse),
      .i_halt          (halt),
      .i_csr_addr      (csr_addr),
      .i_csr_rd_en     (csr_rd_en),
      .i_csr_wr_en     (csr_wr_en),
      .i_csr_wdata     (csr_wdata),
      .o_csr_rdata     (csr_rdata),
      .o_csr_valid     (csr_valid),
      .o_csr_err       (csr_err),
      .o_cycle_count   (cycle_count),
      .o_instret_count (instret_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference counters following the architectural rules.
   logic [63:0] m_cy, m_ir;
   logic        m_inh_cy, m_inh_ir;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cy = '0; m_ir = '0; m_inh_cy = 1'b0; m_inh_ir = 1'b0;
      end else begin
         logic wv;
         wv = csr_wr_en && !csr_rd_en;
         if (wv && csr_addr == 12'hB00)      m_cy[31:0]  = csr_wdata;
         else if (wv && csr_addr == 12'hB80) m_cy[63:32] = csr_wdata;
         else if (!halt && !m_inh_cy)        m_cy = m_cy + 64'd1;
         if (wv && csr_addr == 12'hB02)      m_ir[31:0]  = csr_wdata;
         else if (wv && csr_addr == 12'hB82) m_ir[63:32] = csr_wdata;
         else if (instret_pulse && !halt && !m_inh_ir) m_ir = m_ir + 64'd1;
         if (wv && csr_addr == 12'h320) begin
            m_inh_cy = csr_wdata[0];
            m_inh_ir = csr_wdata[2];
         end
      end
   end

   function automatic logic [31:0] mread(input logic [11:0] a);
      case (a)
         12'hB00, 12'hC00: return m_cy[31:0];
         12'hB80, 12'hC80: return m_cy[63:32];
         12'hB02, 12'hC02: return m_ir[31:0];
         12'hB82, 12'hC82: return m_ir[63:32];
         12'h320:          return {29'b0, m_inh_ir, 1'b0, m_inh_cy};
         default:          return 32'b0;
      endcase
   endfunction

   typedef struct { logic err; logic [31:0] rdata; } exp_t;
   exp_t sb[$];

   // One request on the next edge; response checked just after that edge.
   task automatic csr_req(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [31:0] wd, input logic eerr);
      exp_t e, g;
      @(negedge clk);
      csr_rd_en = rd; csr_wr_en = wr; csr_addr = a; csr_wdata = wd;
      e.err   = eerr;
      e.rdata = (rd && !wr && !eerr) ? mread(a) : 32'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      csr_rd_en = 1'b0; csr_wr_en = 1'b0;
      g = sb.pop_front();
      chk($sformatf("valid@%03h", a), {63'b0, csr_valid}, 64'd1);
      chk($sformatf("err@%03h", a),   {63'b0, csr_err},   {63'b0, g.err});
      chk($sformatf("rdata@%03h", a), {32'b0, csr_rdata}, {32'b0, g.rdata});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] cy0, cy1, ir1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_cy", cycle_count, 0);
      chk("rst_ir", instret_count, 0);
      chk("rst_valid", {63'b0, csr_valid}, 0);
      chk("rst_err", {63'b0, csr_err}, 0);
      chk("rst_rdata", {32'b0, csr_rdata}, 0);

      // free-running cycle count
      repeat (100) @(posedge clk); #1;
      chk("cy_100", cycle_count, 64'd100);
      chk("ir_0", instret_count, 0);
      csr_req(1, 0, 12'hB00, 0, 0);
      chk("rd_b00_100", {32'b0, csr_rdata}, 64'd100);
      @(posedge clk); #1;
      chk("valid_drop", {63'b0, csr_valid}, 0);

      // scattered retires, then halt
      @(negedge clk);
      cy0 = cycle_count;
      for (int i = 0; i < 120; i++) begin
         instret_pulse = (i % 3 == 0);
         @(negedge clk);
      end
      instret_pulse = 1'b0; halt = 1'b1;
      chk("cy_120", cycle_count, cy0 + 64'd120);
      chk("ir_40", instret_count, 64'd40);
      repeat (50) @(posedge clk); #1;
      chk("cy_frozen", cycle_count, cy0 + 64'd120);
      csr_req(1, 0, 12'hC02, 0, 0);
      chk("rd_c02_40", {32'b0, csr_rdata}, 64'd40);
      csr_req(1, 0, 12'hB82, 0, 0);
      chk("rd_b82_0", {32'b0, csr_rdata}, 0);
      chk("cy_still_frozen", cycle_count, cy0 + 64'd120);
      @(negedge clk); halt = 1'b0;

      // carry across bit 31
      csr_req(0, 1, 12'hB00, 32'hFFFF_FFFE, 0);
      csr_req(0, 1, 12'hB80, 32'h0, 0);
      chk("wr_hi_keeps_lo", cycle_count, 64'hFFFF_FFFE);
      repeat (3) @(posedge clk); #1;
      chk("cy_carry", cycle_count, 64'h1_0000_0001);
      csr_req(1, 0, 12'hB80, 0, 0);
      chk("rd_b80_1", {32'b0, csr_rdata}, 64'd1);

      // inhibit
      cy1 = cycle_count;
      csr_req(0, 1, 12'h320, 32'h7, 0);
      chk("inh_old_val_cycle", cycle_count, cy1 + 64'd1);
      cy1 = cycle_count; ir1 = instret_count;
      @(negedge clk); instret_pulse = 1'b1;
      repeat (10) @(posedge clk); #1;
      chk("inh_cy_hold", cycle_count, cy1);
      chk("inh_ir_hold", instret_count, ir1);
      csr_req(1, 0, 12'h320, 0, 0);
      chk("rd_320_5", {32'b0, csr_rdata}, 64'd5);
      csr_req(0, 1, 12'h320, 32'h0, 0);
      chk("inh_clear_edge", cycle_count, cy1);
      @(posedge clk); #1;
      chk("inh_resume", cycle_count, cy1 + 64'd1);
      @(negedge clk); instret_pulse = 1'b0;

      // errors and aliases, back to back
      csr_req(0, 1, 12'hC00, 32'h1234, 1);
      csr_req(1, 0, 12'h123, 0, 1);
      csr_req(1, 1, 12'hB00, 32'h0, 1);
      csr_req(1, 0, 12'hC80, 0, 0);
      csr_req(0, 1, 12'hB02, 32'hFFFF_FFFF, 0);
      csr_req(1, 0, 12'hC82, 0, 0);
      @(negedge clk); instret_pulse = 1'b1;
      @(negedge clk); instret_pulse = 1'b0; #1;
      chk("ir_carry", instret_count, 64'h1_0000_0000);
      chk("cy_model", cycle_count, m_cy);
      chk("ir_model", instret_count, m_ir);

      // async reset with a response in flight
      @(negedge clk); csr_rd_en = 1'b1; csr_addr = 12'hB00;
      @(posedge clk); #2; rst = 1'b1; #1;
      chk("arst_valid", {63'b0, csr_valid}, 0);
      chk("arst_rdata", {32'b0, csr_rdata}, 0);
      chk("arst_cy", cycle_count, 0);
      chk("arst_ir", instret_count, 0);
      @(negedge clk); csr_rd_en = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_no_valid", {63'b0, csr_valid}, 0);
      chk("arst_cy1", cycle_count, 64'd1);
      repeat (4) @(posedge clk); #1;
      chk("arst_cy5", cycle_count, 64'd5);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
